// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus fetch front end.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package kamus_pkg;

   // Canonical no-op (addi x0, x0, 0), shown to ID whenever the buffer is empty
   localparam logic [31:0] KAMUS_NOP = 32'h0000_0013;

   // One buffered fetch: PC, raw instruction word and a misalignment tag
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        misalign;
   } fetch_entry_t;

   // A fetch PC is misaligned when either of its low two bits is set
   function automatic logic addr_misaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage : kamus_pkg

// File: rtl/kamus_fetch_fifo.sv
// Fetch buffer between IF and ID: in-order {pc, instr} queue with a misalign tag and a flush.
// Latency: a word pushed in cycle N is first visible at the output in cycle N+1 (no bypass).
// Backpressure: in_ready_o comes from registered occupancy only; a full buffer refuses a push even if ID pops.
module kamus_fetch_fifo
   import kamus_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = KAMUS_NOP
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [31:0]              in_addr_i,
   input  logic [31:0]              in_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [31:0]              out_addr_o,
   output logic [31:0]              out_data_o,
   output logic                     out_misalign_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Registered state
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   // Goes high on the first clock edge after reset release; gates in_ready_o
   logic             alive_q,  alive_d;

   // Storage is deliberately not reset: out_valid_o masks stale entries
   fetch_entry_t     fifo_mem_q [DEPTH];
   fetch_entry_t     wr_entry_d;
   fetch_entry_t     head_entry;

   logic             push;
   logic             pop;

   // Handshake view derived purely from registered state, so no path from out_ready_i to in_ready_o
   assign in_ready_o  = alive_q & (count_q != FULL_CNT);
   assign out_valid_o = (count_q != '0);
   assign count_o     = count_q;

   // Flush suppresses both transfers in the cycle it is asserted
   assign push = in_valid_i  & in_ready_o  & ~flush_i;
   assign pop  = out_valid_o & out_ready_i & ~flush_i;

   // Next-state for pointers and occupancy; flush wins over push and pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      alive_d  = 1'b1;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers, cleared asynchronously by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         alive_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         alive_q  <= alive_d;
      end
   end

   // Build the entry to store, tagging misaligned PCs now so ID/EX need not recompute it
   always_comb begin
      wr_entry_d          = '0;
      wr_entry_d.addr     = in_addr_i;
      wr_entry_d.data     = in_data_i;
      wr_entry_d.misalign = addr_misaligned(in_addr_i);
   end

   // Tail write on an accepted push
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= wr_entry_d;
      end
   end

   // Output mux: head entry when occupied, otherwise a harmless NOP at PC 0
   always_comb begin
      head_entry     = fifo_mem_q[rd_ptr_q];
      out_addr_o     = '0;
      out_data_o     = NOP_INSTR;
      out_misalign_o = 1'b0;
      if (out_valid_o) begin
         out_addr_o     = head_entry.addr;
         out_data_o     = head_entry.data;
         out_misalign_o = head_entry.misalign;
      end
   end

endmodule : kamus_fetch_fifo

// File: tb/tb_kamus_fetch_fifo.sv
// Self-checking bench for kamus_fetch_fifo: directed scenarios followed by random traffic.
// Reference is a plain queue of {pc, instr}; outputs are compared every cycle, #1 after the rising edge.
// Inputs change on the falling edge only.
module tb_kamus_fetch_fifo;
   import kamus_pkg::*;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_addr_i;
   logic [31:0] in_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_addr_o;
   logic [31:0] out_data_o;
   logic        out_misalign_o;
   logic [2:0]  count_o;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as queues, plus "clocked since reset release"
   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   bit          model_alive = 1'b0;

   always #5 clk_i = ~clk_i;

   kamus_fetch_fifo #(.DEPTH(DEPTH), .NOP_INSTR(32'h0000_0013)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_addr_i      (in_addr_i),
      .in_data_i      (in_data_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_addr_o     (out_addr_o),
      .out_data_o     (out_data_o),
      .out_misalign_o (out_misalign_o),
      .count_o        (count_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against what the model says it should be right now
   task automatic check_outputs(input string tag);
      bit          v;
      logic [31:0] ea, ed;
      logic        em;
      v  = (q_addr.size() != 0);
      ea = v ? q_addr[0] : 32'h0;
      ed = v ? q_data[0] : 32'h0000_0013;
      em = v ? (q_addr[0][1:0] != 2'b00) : 1'b0;
      chk({tag, ".valid"},    32'(out_valid_o),    32'(v));
      chk({tag, ".addr"},     out_addr_o,          ea);
      chk({tag, ".data"},     out_data_o,          ed);
      chk({tag, ".misalign"}, 32'(out_misalign_o), 32'(em));
      chk({tag, ".count"},    32'(count_o),        32'(q_addr.size()));
      chk({tag, ".ready"},    32'(in_ready_o),     32'(model_alive && (q_addr.size() < DEPTH)));
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic fl);
      in_valid_i  = v;
      in_addr_i   = a;
      in_data_i   = d;
      out_ready_i = rdy;
      flush_i     = fl;
   endtask

   // One clock: decide transfers from pre-edge model state, advance the model, then check
   task automatic cycle(input string tag);
      bit          push, pop;
      logic [31:0] a, d;
      push = in_valid_i && model_alive && (q_addr.size() < DEPTH) && !flush_i;
      pop  = (q_addr.size() != 0) && out_ready_i && !flush_i;
      a    = in_addr_i;
      d    = in_data_i;
      @(posedge clk_i);
      #1;
      if (flush_i) begin
         q_addr.delete();
         q_data.delete();
      end else begin
         if (pop) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
         end
         if (push) begin
            q_addr.push_back(a);
            q_data.push_back(d);
         end
      end
      model_alive = 1'b1;
      check_outputs(tag);
      @(negedge clk_i);
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;

      // Reset held for three cycles
      repeat (3) @(posedge clk_i);
      #1;
      check_outputs("reset");
      chk("reset.nop", out_data_o, 32'h0000_0013);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_outputs("release_pre_edge");
      @(negedge clk_i);
      model_alive = 1'b0;
      cycle("release");

      // Fill to full with ID stalled, then an ignored fifth push, then drain
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
         cycle("fill");
      end
      chk("full.count", 32'(count_o), 32'd4);
      drive(1'b1, 32'h10, 32'hFF, 1'b0, 1'b0);
      cycle("full_push_ignored");
      drive(1'b1, 32'h14, 32'hFE, 1'b1, 1'b0);
      #1 chk("full.ready_no_comb_path", 32'(in_ready_o), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle("drain");

      // No bypass: push into empty with ID ready
      drive(1'b1, 32'h100, 32'hDEAD, 1'b1, 1'b0);
      #1 check_outputs("bypass_same_cycle");
      cycle("bypass_next");
      chk("bypass.head", out_data_o, 32'hDEAD);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle("bypass_pop");

      // Two entries, then concurrent push+pop across pointer wrap
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b0);
         cycle("pp_fill");
      end
      for (int i = 2; i < 10; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1, 1'b0);
         cycle("pushpop");
      end
      chk("pushpop.count", 32'(count_o), 32'd2);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (2) cycle("pp_drain");

      // Flush with a concurrent push
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h500 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 1'b0);
         cycle("fl_fill");
      end
      drive(1'b1, 32'h200, 32'h2222, 1'b1, 1'b1);
      cycle("flush");
      chk("flush.valid", 32'(out_valid_o), 32'd0);
      drive(1'b1, 32'h40, 32'h4040, 1'b0, 1'b0);
      cycle("after_flush");
      chk("after_flush.head", out_addr_o, 32'h40);

      // Misalign tagging, then asynchronous reset between edges
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle("mis_clear");
      drive(1'b1, 32'h102, 32'h1111, 1'b0, 1'b0);
      cycle("misalign");
      chk("misalign.flag", 32'(out_misalign_o), 32'd1);
      drive(1'b1, 32'h104, 32'h2222, 1'b1, 1'b0);
      cycle("aligned");
      chk("aligned.flag", 32'(out_misalign_o), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      q_addr.delete();
      q_data.delete();
      model_alive = 1'b0;
      chk("async_reset.valid", 32'(out_valid_o), 32'd0);
      check_outputs("async_reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle("async_release");

      // Random traffic with occasional flushes and misaligned PCs
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_kamus_fetch_fifo
